// File: rtl/pulse_burst_scheduler_pkg.sv
// Shared definitions for the pulse burst scheduler: FSM state encoding.
package pulse_burst_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/pulse_burst_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at the requester after
// the one-hot `last` pointer. It produces a one-hot winner, or zero if none.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] last,
  output logic [N_REQ-1:0] winner
);

  int   last_idx;
  logic found;

  always_comb begin
    winner   = '0;
    last_idx = 0;
    found    = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (last[j]) last_idx = j;
    end
    // Offsets 1..N_REQ visit every requester once, ending with last itself.
    for (int off = 1; off <= N_REQ; off++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && req[j] && (j == ((last_idx + off) % N_REQ))) begin
          winner[j] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pulse_burst_scheduler.sv
// Shares one pulse-train output among N_REQ requesters. A round-robin grant is
// followed by a burst of `count` pulses with the widths latched at grant time.
import pulse_burst_scheduler_pkg::*;

module pulse_burst_scheduler #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4,
  parameter int WID_W = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] count,
  input  logic [WID_W-1:0]       width_hi,
  input  logic [WID_W-1:0]       width_lo,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic                   signal,
  output logic [N_REQ-1:0]       done
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WID_W-1:0] WID_ONE = WID_W'(1);
  // The last-winner pointer resets to the top requester, giving requester 0
  // highest priority.
  localparam logic [N_REQ-1:0] LAST_RST = {1'b1, {(N_REQ-1){1'b0}}};

  state_t           state_reg, state_next;
  logic [WID_W-1:0] phase_reg, phase_next;
  logic [WID_W-1:0] wh_reg, wh_next;
  logic [WID_W-1:0] wl_reg, wl_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic [N_REQ-1:0] last_reg, last_next;
  logic [N_REQ-1:0] done_reg, done_next;
  logic             signal_reg, signal_next;
  logic [N_REQ-1:0] winner;
  logic [CNT_W-1:0] sel_count;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (req),
    .last   (last_reg),
    .winner (winner)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      phase_reg     <= '0;
      wh_reg        <= '0;
      wl_reg        <= '0;
      remaining_reg <= '0;
      grant_reg     <= '0;
      last_reg      <= LAST_RST;
      done_reg      <= '0;
      signal_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      wh_reg        <= wh_next;
      wl_reg        <= wl_next;
      remaining_reg <= remaining_next;
      grant_reg     <= grant_next;
      last_reg      <= last_next;
      done_reg      <= done_next;
      signal_reg    <= signal_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    wh_next        = wh_reg;
    wl_next        = wl_reg;
    remaining_next = remaining_reg;
    grant_next     = grant_reg;
    last_next      = last_reg;
    done_next      = '0;
    signal_next    = signal_reg;
    sel_count      = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (winner[j]) sel_count = sel_count | count[j*CNT_W +: CNT_W];
    end

    // Outputs are computed from the next state so they change on the same
    // edge as the state they describe.
    unique case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          grant_next     = winner;
          remaining_next = sel_count;
          wh_next        = width_hi;
          wl_next        = width_lo;
          phase_next     = width_hi;
          if (sel_count != '0) begin
            state_next  = ST_HIGH;
            signal_next = 1'b1;
          end else begin
            state_next = ST_DONE;
            done_next  = winner;
          end
        end
      end
      ST_HIGH: begin
        if (phase_reg == '0) begin
          state_next  = ST_LOW;
          phase_next  = wl_reg;
          signal_next = 1'b0;
        end else begin
          phase_next = phase_reg - WID_ONE;
        end
      end
      ST_LOW: begin
        if (phase_reg == '0) begin
          remaining_next = remaining_reg - CNT_ONE;
          if (remaining_reg == CNT_ONE) begin
            state_next = ST_DONE;
            done_next  = grant_reg;
          end else begin
            state_next  = ST_HIGH;
            phase_next  = wh_reg;
            signal_next = 1'b1;
          end
        end else begin
          phase_next = phase_reg - WID_ONE;
        end
      end
      ST_DONE: begin
        state_next  = ST_IDLE;
        last_next   = grant_reg;
        grant_next  = '0;
        signal_next = 1'b0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign grant  = grant_reg;
  assign busy   = |grant_reg;
  assign signal = signal_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Directed bench for pulse_burst_scheduler: expected bursts are queued when
// requests are driven and compared against each observed burst.
module tb_pulse_burst_scheduler;

  localparam int N_REQ = 4;
  localparam int CNT_W = 4;
  localparam int WID_W = 3;

  logic                   clk;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] count;
  logic [WID_W-1:0]       width_hi;
  logic [WID_W-1:0]       width_lo;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic                   signal;
  logic [N_REQ-1:0]       done;

  typedef struct {
    logic [N_REQ-1:0] g;
    int               c;
    int               wh;
    int               wl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   waits;

  pulse_burst_scheduler #(.N_REQ(N_REQ), .CNT_W(CNT_W), .WID_W(WID_W)) dut (
    .clock    (clk),
    .reset    (reset),
    .req      (req),
    .count    (count),
    .width_hi (width_hi),
    .width_lo (width_lo),
    .grant    (grant),
    .busy     (busy),
    .signal   (signal),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [N_REQ-1:0] g, input int c, input int wh, input int wl);
    exp_t e;
    e.g = g; e.c = c; e.wh = wh; e.wl = wl;
    sb.push_back(e);
  endtask

  // Watch one burst from grant to the IDLE cycle after done.
  task automatic observe(input string tag, output int nwait);
    exp_t e;
    int n, hi, pulses, run, maxrun;
    logic prev;
    nwait = 0;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    forever begin
      tick();
      if (grant != '0 || nwait >= 100) break;
      nwait++;
    end
    check({tag, "_grant"}, 32'(grant), 32'(e.g));
    n = 0; hi = 0; pulses = 0; run = 0; maxrun = 0; prev = 1'b0;
    while (done == '0 && n < 1000) begin
      if (signal && !prev) pulses++;
      if (signal) begin
        hi++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      prev = signal;
      n++;
      tick();
    end
    check({tag, "_done"}, 32'(done), 32'(e.g));
    check({tag, "_grant_at_done"}, 32'(grant), 32'(e.g));
    check({tag, "_signal_at_done"}, 32'(signal), 32'd0);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    check({tag, "_burst_cycles"}, 32'(n), 32'(e.c * (e.wh + e.wl + 2)));
    check({tag, "_pulses"}, 32'(pulses), 32'(e.c));
    check({tag, "_high_cycles"}, 32'(hi), 32'(e.c * (e.wh + 1)));
    check({tag, "_high_width"}, 32'(maxrun), (e.c > 0) ? 32'(e.wh + 1) : 32'd0);
    tick();
    check({tag, "_idle_grant"}, 32'(grant), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    $display("burst %s grant=%b pulses=%0d cycles=%0d wait=%0d", tag, e.g, pulses, n, nwait);
  endtask

  initial begin
    reset = 1'b0; req = '0; count = '0; width_hi = '0; width_lo = '0;
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_signal", 32'(signal), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    tick();

    // Contention: all four requesters, one pulse each, minimum widths.
    count = {4'd1, 4'd1, 4'd1, 4'd1};
    req = 4'b1111;
    push(4'b0001, 1, 0, 0);
    push(4'b0010, 1, 0, 0);
    push(4'b0100, 1, 0, 0);
    push(4'b1000, 1, 0, 0);
    push(4'b0001, 1, 0, 0);
    observe("rr0", waits);
    check("rr0_wait", 32'(waits), 32'd0);
    for (int k = 1; k < 5; k++) begin
      observe($sformatf("rr%0d", k), waits);
      check($sformatf("rr%0d_idle_gap", k), 32'(waits), 32'd0);
    end
    req = '0;
    repeat (2) tick();

    // Single request: 3 pulses of 2 high / 2 low, done 12 cycles after grant.
    count = '0; count[1*CNT_W +: CNT_W] = 4'd3;
    width_hi = 3'd1; width_lo = 3'd1;
    req = 4'b0010;
    push(4'b0010, 3, 1, 1);
    observe("single", waits);
    check("single_latency", 32'(waits), 32'd0);
    req = '0;
    repeat (2) tick();

    // Count 0: grant and done for a single cycle, no pulse.
    count = '0;
    req = 4'b0100;
    push(4'b0100, 0, 1, 1);
    observe("count0", waits);
    req = '0;
    repeat (2) tick();

    // Mid-burst changes must not alter the burst in progress.
    count = '0; count[0 +: CNT_W] = 4'd2;
    width_hi = 3'd2; width_lo = 3'd1;
    req = 4'b0001;
    push(4'b0001, 2, 2, 1);
    fork
      observe("midchg", waits);
      begin
        repeat (3) tick();
        req = '0;
        count[0 +: CNT_W] = 4'd5;
        width_hi = 3'd0;
      end
    join
    repeat (2) tick();

    // Reset during HIGH; the pointer then favours requester 0 again.
    count = '0; count[0 +: CNT_W] = 4'd3;
    width_hi = 3'd3; width_lo = 3'd0;
    req = 4'b0001;
    repeat (2) tick();
    check("rstmid_signal_before", 32'(signal), 32'd1);
    reset = 1'b0;
    req = '0;
    tick();
    check("rstmid_signal", 32'(signal), 32'd0);
    check("rstmid_grant", 32'(grant), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b1;
    count = {4'd1, 4'd0, 4'd0, 4'd1};
    width_hi = 3'd0; width_lo = 3'd0;
    req = 4'b1001;
    push(4'b0001, 1, 0, 0);
    observe("postrst0", waits);
    check("postrst0_wait", 32'(waits), 32'd0);
    req = 4'b1000;
    push(4'b1000, 1, 0, 0);
    observe("postrst3", waits);
    req = '0;
    repeat (2) tick();

    // Maximum widths and count: 240 cycles before DONE.
    count = '0; count[0 +: CNT_W] = 4'd15;
    width_hi = 3'd7; width_lo = 3'd7;
    req = 4'b0001;
    push(4'b0001, 15, 7, 7);
    observe("maxwid", waits);
    req = '0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
